bus_handshake_slave: RTL and testbench

- Module-side adapter placed directly downstream of the bus CDC bridge, in a destination clock domain.
- Accepts the bridge's one-cycle pulsed bus transactions (address/data/we/we_ram are valid only during the pulse and zero otherwise) for an address window.
- Converts each transaction into a held req/ack handshake toward a slow backend peripheral.
- Drives module_busy back to the bridge so the CPU-side halt lasts until the backend completes. The bridge slot feeding this block must have module_busy_en tied to 1.

---
 rtl/bus_handshake_slave_if.sv | 31 +++
 rtl/bus_handshake_slave.sv | 125 ++++++++++++
 tb/tb_bus_handshake_slave.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_handshake_slave_if.sv
// Bus-side and backend-side signal bundle for bus_handshake_slave.
// The slave modport is the adapter; the master modport is the bridge plus backend environment.
interface bus_handshake_slave_if #(
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32
);
  logic [AddressWidth-1:0] bus_address_i;
  logic [DataWidth-1:0]    bus_data_i;
  logic                    bus_we_i;
  logic [3:0]              bus_we_ram_i;
  logic [DataWidth-1:0]    bus_data_o;
  logic                    module_busy_o;

  logic                    be_req_o;
  logic [AddressWidth-1:0] be_addr_o;
  logic                    be_we_o;
  logic [3:0]              be_strb_o;
  logic [DataWidth-1:0]    be_wdata_o;
  logic                    be_ack_i;
  logic [DataWidth-1:0]    be_rdata_i;

  modport slave (
    input  bus_address_i, bus_data_i, bus_we_i, bus_we_ram_i, be_ack_i, be_rdata_i,
    output bus_data_o, module_busy_o, be_req_o, be_addr_o, be_we_o, be_strb_o, be_wdata_o
  );

  modport master (
    output bus_address_i, bus_data_i, bus_we_i, bus_we_ram_i, be_ack_i, be_rdata_i,
    input  bus_data_o, module_busy_o, be_req_o, be_addr_o, be_we_o, be_strb_o, be_wdata_o
  );
endinterface

// File: rtl/bus_handshake_slave.sv
// Turns one-cycle pulsed bridge transactions in an address window into a held
// req/ack handshake toward a slow backend, holding module_busy until completion.
module bus_handshake_slave #(
  parameter int                    AddressWidth  = 32,
  parameter int                    DataWidth     = 32,
  parameter logic [AddressWidth-1:0] AddressStart = 32'h0000_1000,
  parameter logic [AddressWidth-1:0] AddressEnd   = 32'h0000_10FF,
  parameter int                    TimeoutCycles = 255,
  parameter logic [DataWidth-1:0]  ErrorData     = 32'hDEAD_BEEF
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  bus_handshake_slave_if.slave  bus,
  input  logic                  flags_clear_i,
  output logic                  timeout_flag_o,
  output logic                  overrun_flag_o
);

  localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  typedef enum logic {IDLE, REQ} state_e;

  function automatic logic in_window(input logic [AddressWidth-1:0] a);
    return (a >= AddressStart) && (a <= AddressEnd);
  endfunction

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    req_q, req_d;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic                    we_q, we_d;
  logic [3:0]              strb_q, strb_d;
  logic [DataWidth-1:0]    wdata_q, wdata_d;
  logic [DataWidth-1:0]    rdata_q, rdata_d;
  logic                    timeout_q, timeout_d;
  logic                    overrun_q, overrun_d;
  logic                    hit, timeout_now, timeout_set, overrun_set;

  assign hit         = in_window(bus.bus_address_i);
  assign timeout_now = (TimeoutCycles != 0) && (cnt_q == CntLast);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    addr_d      = addr_q;
    we_d        = we_q;
    strb_d      = strb_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    timeout_set = 1'b0;
    overrun_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          addr_d  = bus.bus_address_i - AddressStart;
          we_d    = bus.bus_we_i;
          strb_d  = bus.bus_we_ram_i;
          wdata_d = bus.bus_data_i;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        // A second hit is never queued, even on the completion edge.
        overrun_set = hit;
        if (bus.be_ack_i) begin
          rdata_d = we_q ? '0 : bus.be_rdata_i;
          req_d   = 1'b0;
          state_d = IDLE;
        end else if (timeout_now) begin
          rdata_d     = we_q ? '0 : ErrorData;
          timeout_set = 1'b1;
          req_d       = 1'b0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Set beats a simultaneous clear.
    timeout_d = timeout_set | (timeout_q & ~flags_clear_i);
    overrun_d = overrun_set | (overrun_q & ~flags_clear_i);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      strb_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      strb_q    <= strb_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.be_req_o      = req_q;
  assign bus.module_busy_o = req_q;
  assign bus.be_addr_o     = addr_q;
  assign bus.be_we_o       = we_q;
  assign bus.be_strb_o     = strb_q;
  assign bus.be_wdata_o    = wdata_q;
  assign bus.bus_data_o    = rdata_q;
  assign timeout_flag_o    = timeout_q;
  assign overrun_flag_o    = overrun_q;

endmodule

// File: tb/tb_bus_handshake_slave.sv
// Self-checking bench for bus_handshake_slave: directed and random transactions
// checked against a transaction-level model of the window/handshake rules.
module tb_bus_handshake_slave;
  localparam int          AW      = 32;
  localparam int          DW      = 32;
  localparam int          T       = 4;
  localparam logic [31:0] A_START = 32'h0000_1000;
  localparam logic [31:0] A_END   = 32'h0000_10FF;
  localparam logic [31:0] ERR     = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flags_clear = 1'b0;
  logic timeout_flag, overrun_flag;

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] exp_rd = '0;
  logic        exp_to = 1'b0;
  logic        exp_ovr = 1'b0;
  logic [31:0] exp_addr = '0;
  logic        exp_we = 1'b0;
  logic [3:0]  exp_strb = '0;
  logic [31:0] exp_wdata = '0;

  bus_handshake_slave_if #(.AddressWidth(AW), .DataWidth(DW)) bif ();

  bus_handshake_slave #(
    .AddressWidth(AW), .DataWidth(DW), .AddressStart(A_START), .AddressEnd(A_END),
    .TimeoutCycles(T), .ErrorData(ERR)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .bus(bif), .flags_clear_i(flags_clear),
    .timeout_flag_o(timeout_flag), .overrun_flag_o(overrun_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no end of test, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bif.bus_address_i = '0;
    bif.bus_data_i    = '0;
    bif.bus_we_i      = 1'b0;
    bif.bus_we_ram_i  = '0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".bus_data"}, bif.bus_data_o, exp_rd);
    chk({tag, ".timeout_flag"}, timeout_flag, exp_to);
    chk({tag, ".overrun_flag"}, overrun_flag, exp_ovr);
    chk({tag, ".be_addr"}, bif.be_addr_o, exp_addr);
    chk({tag, ".be_we"}, bif.be_we_o, exp_we);
    chk({tag, ".be_strb"}, bif.be_strb_o, exp_strb);
    chk({tag, ".be_wdata"}, bif.be_wdata_o, exp_wdata);
  endtask

  // Called just after a falling edge. d: REQ cycle carrying ack (d >= T never acks);
  // ovr_c / clr_c: REQ cycle carrying a second hit / a flag clear (-1 = none).
  task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic we,
                     input logic [3:0] strb, input int d, input int ovr_c,
                     input int clr_c, input logic [31:0] rd);
    logic hit, timed;
    int   exp_w;
    hit   = (a >= A_START) && (a <= A_END);
    timed = hit && (d >= T);
    exp_w = !hit ? 0 : ((d < T) ? d + 1 : T);

    bif.bus_address_i = a;
    bif.bus_data_i    = wd;
    bif.bus_we_i      = we;
    bif.bus_we_ram_i  = strb;
    @(negedge clk);
    bus_idle();
    if (hit) begin
      exp_addr  = a - A_START;
      exp_we    = we;
      exp_strb  = strb;
      exp_wdata = wd;
    end
    chk("req_after_strobe", bif.be_req_o, hit);
    chk_state("accept");

    for (int c = 0; c <= exp_w; c++) begin
      chk("busy", bif.module_busy_o, (c < exp_w));
      chk("req", bif.be_req_o, (c < exp_w));
      if (c == exp_w) break;
      bif.be_ack_i   = (c == d);
      bif.be_rdata_i = (c == d) ? rd : $urandom;
      flags_clear    = (c == clr_c);
      if (c == ovr_c) begin
        bif.bus_address_i = A_START + $urandom_range(0, 255);
        bif.bus_data_i    = $urandom;
        bif.bus_we_i      = 1'($urandom_range(0, 1));
        bif.bus_we_ram_i  = 4'($urandom_range(0, 15));
      end else begin
        bus_idle();
      end
      if (c == clr_c) begin
        exp_to  = 1'b0;
        exp_ovr = 1'b0;
      end
      if (c == ovr_c) exp_ovr = 1'b1;
      if (c == exp_w - 1) begin
        if (timed) exp_to = 1'b1;
        exp_rd = we ? 32'h0 : (timed ? ERR : rd);
      end
      @(negedge clk);
    end
    bif.be_ack_i = 1'b0;
    flags_clear  = 1'b0;
    bus_idle();
    chk_state("complete");
  endtask

  task automatic clear_flags();
    flags_clear = 1'b1;
    @(negedge clk);
    flags_clear = 1'b0;
    exp_to  = 1'b0;
    exp_ovr = 1'b0;
    chk("clear.timeout_flag", timeout_flag, exp_to);
    chk("clear.overrun_flag", overrun_flag, exp_ovr);
  endtask

  initial begin
    bus_idle();
    bif.be_ack_i   = 1'b0;
    bif.be_rdata_i = '0;
    #1;
    chk("reset.req", bif.be_req_o, 1'b0);
    chk("reset.busy", bif.module_busy_o, 1'b0);
    chk_state("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Write with ack on the fourth REQ cycle, then read acked immediately
    txn(32'h1004, 32'h1234_5678, 1'b1, 4'hF, 3, -1, -1, 32'h0);
    txn(32'h1010, 32'h0, 1'b0, 4'hF, 0, -1, -1, 32'hA5A5_A5A5);
    repeat (3) begin
      @(negedge clk);
      chk("bus_data_hold", bif.bus_data_o, exp_rd);
    end

    // Read timeout, then clear
    txn(32'h1020, 32'h0, 1'b0, 4'h3, 9, -1, -1, 32'h0);
    clear_flags();

    // Out-of-window and boundary addresses
    txn(32'h0FFC, 32'h1111_1111, 1'b1, 4'hF, 0, -1, -1, 32'h0);
    txn(32'h1100, 32'h2222_2222, 1'b1, 4'hF, 0, -1, -1, 32'h0);
    txn(32'h0000, 32'h3333_3333, 1'b1, 4'hF, 0, -1, -1, 32'h0);
    txn(32'h1000, 32'h4444_4444, 1'b0, 4'h1, 1, -1, -1, 32'h5555_0000);
    txn(32'h10FF, 32'h6666_6666, 1'b1, 4'h8, 1, -1, -1, 32'h0);

    // Overrun mid-request and on the ack edge; next hit on the first idle cycle
    txn(32'h1030, 32'hCAFE_0001, 1'b1, 4'hC, 2, 1, -1, 32'h0);
    txn(32'h1034, 32'h0, 1'b0, 4'hF, 2, 2, -1, 32'h7777_8888);
    txn(32'h1038, 32'h0, 1'b0, 4'hF, 1, -1, -1, 32'h9999_AAAA);

    // Set wins over a simultaneous clear
    txn(32'h1040, 32'h0, 1'b0, 4'hF, 2, 1, 1, 32'h1357_9BDF);
    txn(32'h1044, 32'h0, 1'b0, 4'hF, 9, -1, T - 1, 32'h0);

    // Asynchronous reset in the middle of a request
    bif.bus_address_i = A_START + 32'h48;
    bif.bus_we_ram_i  = 4'hF;
    @(negedge clk);
    bus_idle();
    chk("pre_reset.busy", bif.module_busy_o, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_rd = '0; exp_to = 1'b0; exp_ovr = 1'b0;
    exp_addr = '0; exp_we = 1'b0; exp_strb = '0; exp_wdata = '0;
    chk("async_reset.req", bif.be_req_o, 1'b0);
    chk("async_reset.busy", bif.module_busy_o, 1'b0);
    chk_state("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txn(32'h1050, 32'h0, 1'b0, 4'hF, 2, -1, -1, 32'h0BAD_F00D);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      int oc, cc;
      case ($urandom_range(0, 5))
        0, 1, 2: a = A_START + $urandom_range(0, 255);
        3:       a = $urandom_range(0, 32'h0FFF);
        4:       a = A_END + 32'd1 + $urandom_range(0, 4096);
        default: a = $urandom;
      endcase
      oc = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : -1;
      cc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1;
      txn(a, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          int'($urandom_range(0, 6)), oc, cc, $urandom);
      if ($urandom_range(0, 7) == 0) clear_flags();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
